// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: one shared leaky-integrate-and-fire datapath, time-multiplexed over NUM_NEURONS neurons
//   clk_i         rising-edge clock
//   reset_ni      asynchronous active-low reset, clears all state
//   start_i       request one timestep (dropped and flagged if busy)
//   current_in_i  4-bit current per neuron, neuron i at [4i+3:4i]
//   probe_sel_i   membrane readout select
//   busy_o        timestep in progress
//   done_o        one-cycle pulse when spike_vec_o updates
//   spike_vec_o   spikes of the last completed timestep
//   probe_state_o registered membrane[probe_sel_i]
//   overrun_o     sticky dropped-start flag
module lif_tdm_scheduler #(
   parameter int                 NUM_NEURONS   = 4,
   parameter int                 WIDTH         = 8,
   parameter logic [WIDTH-1:0]   THRESHOLD     = 8'd30,
   parameter int                 LEAK_SHIFT    = 2,
   parameter int                 REFRACT_STEPS = 2
) (
   input  logic                           clk_i,
   input  logic                           reset_ni,
   input  logic                           start_i,
   input  logic [4*NUM_NEURONS-1:0]       current_in_i,
   input  logic [$clog2(NUM_NEURONS)-1:0] probe_sel_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [NUM_NEURONS-1:0]         spike_vec_o,
   output logic [WIDTH-1:0]               probe_state_o,
   output logic                           overrun_o
);
   localparam int IW = $clog2(NUM_NEURONS);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] UPDATE = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]               state_q, state_d;
   logic [IW-1:0]            idx_q;
   logic [4*NUM_NEURONS-1:0] snap_q;
   logic [WIDTH-1:0]         mem_q [NUM_NEURONS];
   logic [2:0]               refr_q [NUM_NEURONS];
   logic [NUM_NEURONS-1:0]   stage_q, stage_d;
   logic [NUM_NEURONS-1:0]   spike_q;
   logic                     overrun_q;
   logic [WIDTH-1:0]         probe_q, probe_d;

   logic [WIDTH-1:0] m_w, n_w;
   logic [3:0]       cur_w;
   logic [WIDTH:0]   sum_w;
   logic             refr_act_w, spk_w, last_w;

   // Datapath for the neuron currently selected by idx_q; the extra top bit catches overflow for saturation
   always_comb begin
      m_w        = mem_q[idx_q];
      cur_w      = snap_q[4*idx_q +: 4];
      sum_w      = {1'b0, m_w} - {1'b0, m_w >> LEAK_SHIFT} + {{(WIDTH-3){1'b0}}, cur_w};
      n_w        = sum_w[WIDTH] ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
      refr_act_w = refr_q[idx_q] != 3'd0;
      spk_w      = !refr_act_w && (n_w >= THRESHOLD);
      last_w     = idx_q == IW'(NUM_NEURONS-1);
      stage_d         = stage_q;
      stage_d[idx_q]  = spk_w;
      state_d    = (state_q == IDLE)   ? (start_i ? UPDATE : IDLE) :
                   (state_q == UPDATE) ? (last_w ? DONE : UPDATE) : IDLE;
      probe_d    = (int'(probe_sel_i) < NUM_NEURONS) ? mem_q[probe_sel_i] : '0;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         snap_q    <= '0;
         mem_q     <= '{default: '0};
         refr_q    <= '{default: '0};
         stage_q   <= '0;
         spike_q   <= '0;
         overrun_q <= 1'b0;
         probe_q   <= '0;
      end else begin
         state_q   <= state_d;
         probe_q   <= probe_d;
         overrun_q <= overrun_q | (start_i && state_q != IDLE);
         if (state_q == IDLE && start_i) begin
            snap_q <= current_in_i;
            idx_q  <= '0;
         end
         if (state_q == UPDATE) begin
            stage_q <= stage_d;
            idx_q   <= last_w ? '0 : idx_q + 1'b1;
            if (last_w) spike_q <= stage_d;
            if (refr_act_w) begin
               refr_q[idx_q] <= refr_q[idx_q] - 3'd1;
               mem_q[idx_q]  <= '0;
            end else if (spk_w) begin
               refr_q[idx_q] <= 3'(REFRACT_STEPS);
               mem_q[idx_q]  <= '0;
            end else begin
               mem_q[idx_q]  <= n_w;
            end
         end
      end
   end

   assign busy_o        = state_q != IDLE;
   assign done_o        = state_q == DONE;
   assign spike_vec_o   = spike_q;
   assign probe_state_o = probe_q;
   assign overrun_o     = overrun_q;
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb_lif_tdm_scheduler: directed self-checking bench for lif_tdm_scheduler (N=4, WIDTH=8, TH=30, LEAK=2, REFR=2)
module tb_lif_tdm_scheduler;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] current_in = '0;
   logic [1:0]  probe_sel = '0;
   logic        busy, done;
   logic [3:0]  spike_vec;
   logic [7:0]  probe_state;
   logic        overrun;
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  last_spike;

   lif_tdm_scheduler #(
      .NUM_NEURONS(4), .WIDTH(8), .THRESHOLD(8'd30), .LEAK_SHIFT(2), .REFRACT_STEPS(2)
   ) dut (
      .clk_i(clk), .reset_ni(reset_n), .start_i(start), .current_in_i(current_in),
      .probe_sel_i(probe_sel), .busy_o(busy), .done_o(done), .spike_vec_o(spike_vec),
      .probe_state_o(probe_state), .overrun_o(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One timestep: c0 is seen at the start edge, c1 afterwards; pulse adds a start sampled at E2
   task automatic run_step(input logic [15:0] c0, input logic [15:0] c1, input bit pulse);
      int k;
      bit got;
      k = 0;
      got = 0;
      current_in = c0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      current_in = c1;
      chk("busy_at_e0", busy, 1);
      while (k < 10 && !got) begin
         @(posedge clk); #1;
         k++;
         start = pulse && (k == 1);
         if (done) got = 1;
      end
      start = 1'b0;
      chk("done_latency", k, 4);
      last_spike = spike_vec;
      @(posedge clk); #1;
      chk("idle_after_done", {busy, done}, 0);
   endtask

   initial begin
      int dones;
      logic [7:0] leak_exp [12];
      leak_exp = '{8'd7, 8'd13, 8'd17, 8'd20, 8'd22, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd28, 8'd28};

      // Reset
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("reset_busy", busy, 0);
      end
      chk("reset_done", done, 0);
      chk("reset_spike", spike_vec, 0);
      chk("reset_probe", probe_state, 0);
      chk("reset_overrun", overrun, 0);

      // Integrate and fire on neuron 0
      probe_sel = 2'd0;
      run_step(16'h000F, 16'h000F, 0); chk("if1_mem", probe_state, 15); chk("if1_spk", last_spike, 4'b0000);
      run_step(16'h000F, 16'h000F, 0); chk("if2_mem", probe_state, 27); chk("if2_spk", last_spike, 4'b0000);
      run_step(16'h000F, 16'h000F, 0); chk("if3_mem", probe_state, 0);  chk("if3_spk", last_spike, 4'b0001);
      run_step(16'h000F, 16'h000F, 0); chk("if4_mem", probe_state, 0);  chk("if4_spk", last_spike, 4'b0000);
      run_step(16'h000F, 16'h000F, 0); chk("if5_mem", probe_state, 0);  chk("if5_spk", last_spike, 4'b0000);
      run_step(16'h000F, 16'h000F, 0); chk("if6_mem", probe_state, 15); chk("if6_spk", last_spike, 4'b0000);

      // Leak equilibrium on neuron 2
      probe_sel = 2'd2;
      for (int i = 0; i < 12; i++) begin
         run_step(16'h0700, 16'h0700, 0);
         chk($sformatf("leak%0d_mem", i), probe_state, leak_exp[i]);
         chk($sformatf("leak%0d_spk", i), last_spike, 4'b0000);
      end

      // Overrun: extra start during UPDATE
      probe_sel = 2'd3;
      run_step(16'hA000, 16'hA000, 1);
      chk("ovr_flag", overrun, 1);
      dones = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("ovr_no_extra_done", dones, 0);
      chk("ovr_mem3_once", probe_state, 10);
      chk("ovr_still_idle", busy, 0);

      // Snapshot: current removed after the start edge
      probe_sel = 2'd1;
      run_step(16'h00F0, 16'h0000, 0);
      chk("snap_mem1", probe_state, 15);

      // Reset mid-sweep during idx 1
      probe_sel = 2'd0;
      current_in = 16'h000F;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_overrun", overrun, 0);
      chk("mid_rst_probe", probe_state, 0);
      chk("mid_rst_spike", spike_vec, 0);
      dones = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      reset_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("mid_rst_no_done", dones, 0);
      run_step(16'h000F, 16'h000F, 0);
      chk("fresh_mem0", probe_state, 15);
      chk("fresh_spk", last_spike, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
